board_gen_param: RTL and testbench

//  Parametrised Flood-It board generator. On START, fills a SIZE x SIZE board with pseudo-random

---
 rtl/flood_pkg.sv | 27 ++
 rtl/lfsr_galois.sv | 41 ++++
 rtl/board_gen_param.sv | 266 ++++++++++++++++++++++++++
 tb/tb_board_gen_param.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flood_pkg.sv
// Shared definitions for the Flood-It board generator.
//   gen_state_t : generator FSM states
//   MaxSize, ColorW, LfsrW, LfsrTaps, DefaultSeed, MaxTries : default parameter values
//   size_w()    : width needed to hold a board edge of 0..max_size
package flood_pkg;

  localparam int unsigned MaxSize     = 26;
  localparam int unsigned ColorW      = 3;
  localparam int unsigned LfsrW       = 16;
  localparam logic [15:0] LfsrTaps    = 16'hB400;
  localparam logic [15:0] DefaultSeed = 16'hDAD7;
  localparam int unsigned MaxTries    = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDraw,
    StWrite,
    StDone,
    StErr
  } gen_state_t;

  function automatic int unsigned size_w(input int unsigned max_size);
    return $clog2(max_size + 1);
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR, shifting right with feedback mask LFSR_TAPS applied when the
// outgoing bit is 1. A nonzero state never steps to zero.
//   clk_i, rst_ni : clock, async active-low reset (state <- RESET_VAL)
//   load_i/seed_i : load seed (has priority over step)
//   step_i        : advance one step
//   state_o       : current state
module lfsr_galois #(
  parameter int unsigned       LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] RESET_VAL = 16'hDAD7
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              step_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (step_i) begin
      state_d = (state_q >> 1) ^ ({LFSR_W{state_q[0]}} & LFSR_TAPS);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RESET_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/board_gen_param.sv
// Flood-It board generator. On START fills a SIZE x SIZE board in row-major
// order through a one-cell-per-strobe write port. Colours come from an LFSR by
// rejection sampling; NO_ADJ forbids matching the left/upper neighbour. After
// MAX_TRIES rejections the smallest legal colour is used instead.
//   CLOCK, RESET_N          : clock, async active-low reset
//   START, ABORT            : level request (sampled in idle) / cancel
//   SEED, SIZE, COLOR_NUM,
//   NO_ADJ                  : configuration, captured on accepted START
//   WR_EN/ROW/COL/COLOR     : registered board RAM write port
//   BUSY, READY, ERROR      : status (READY/ERROR held until START drops)
module board_gen_param
  import flood_pkg::*;
#(
  parameter int unsigned       MAX_SIZE     = MaxSize,
  parameter int unsigned       COLOR_W      = ColorW,
  parameter int unsigned       LFSR_W       = LfsrW,
  parameter logic [LFSR_W-1:0] LFSR_TAPS    = LfsrTaps,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = DefaultSeed,
  parameter int unsigned       MAX_TRIES    = MaxTries,
  localparam int unsigned      SIZE_W       = size_w(MAX_SIZE)
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               START,
  input  logic               ABORT,
  input  logic [LFSR_W-1:0]  SEED,
  input  logic [SIZE_W-1:0]  SIZE,
  input  logic [COLOR_W:0]   COLOR_NUM,
  input  logic               NO_ADJ,
  output logic               WR_EN,
  output logic [SIZE_W-1:0]  WR_ROW,
  output logic [SIZE_W-1:0]  WR_COL,
  output logic [COLOR_W-1:0] WR_COLOR,
  output logic               BUSY,
  output logic               READY,
  output logic               ERROR
);

  localparam int unsigned      NumColors = 2 ** COLOR_W;
  localparam int unsigned      TryW      = $clog2(MAX_TRIES + 1);
  localparam logic [COLOR_W:0] NcolMax   = (COLOR_W + 1)'(NumColors);
  localparam logic [SIZE_W-1:0] SizeMax  = SIZE_W'(MAX_SIZE);

  // True when colour c may not be placed in the current cell.
  function automatic logic excluded(input logic [COLOR_W-1:0] c,
                                    input logic [COLOR_W:0]   ncol,
                                    input logic               no_adj,
                                    input logic               has_left,
                                    input logic [COLOR_W-1:0] left,
                                    input logic               has_above,
                                    input logic [COLOR_W-1:0] above);
    return ({1'b0, c} >= ncol) ||
           (no_adj && ((has_left && c == left) || (has_above && c == above)));
  endfunction

  gen_state_t         state_q, state_d;
  logic               busy_q, busy_d, ready_q, ready_d, error_q, error_d;
  logic               wr_en_q, wr_en_d;
  logic [SIZE_W-1:0]  wr_row_q, wr_row_d, wr_col_q, wr_col_d;
  logic [COLOR_W-1:0] wr_color_q, wr_color_d;
  logic [SIZE_W-1:0]  row_q, row_d, col_q, col_d, size_q, size_d;
  logic [COLOR_W:0]   ncol_q, ncol_d;
  logic               no_adj_q, no_adj_d;
  logic [TryW-1:0]    tries_q, tries_d;
  logic [COLOR_W-1:0] left_q, left_d;
  logic [COLOR_W-1:0] rowbuf_q [MAX_SIZE];

  logic               lfsr_load, lfsr_step, rowbuf_we;
  logic [LFSR_W-1:0]  lfsr_state, seed_eff;
  logic [COLOR_W-1:0] cand, above, fallback;
  logic               cand_reject, cfg_bad, last_col, last_row, last_try;
  logic               unused_lfsr_hi;

  assign seed_eff = (SEED == '0) ? DEFAULT_SEED : SEED;

  lfsr_galois #(
    .LFSR_W    (LFSR_W),
    .LFSR_TAPS (LFSR_TAPS),
    .RESET_VAL (DEFAULT_SEED)
  ) u_lfsr (
    .clk_i   (CLOCK),
    .rst_ni  (RESET_N),
    .load_i  (lfsr_load),
    .seed_i  (seed_eff),
    .step_i  (lfsr_step),
    .state_o (lfsr_state)
  );

  assign cand           = lfsr_state[COLOR_W-1:0];
  assign unused_lfsr_hi = ^lfsr_state[LFSR_W-1:COLOR_W];
  assign above          = rowbuf_q[col_q];

  assign cand_reject = excluded(cand, ncol_q, no_adj_q, col_q != '0, left_q, row_q != '0, above);
  assign cfg_bad     = (size_q == '0) || (size_q > SizeMax) ||
                       (ncol_q < (COLOR_W + 1)'(2)) || (ncol_q > NcolMax) ||
                       (no_adj_q && ncol_q < (COLOR_W + 1)'(3));
  assign last_col    = (col_q == size_q - SIZE_W'(1));
  assign last_row    = (row_q == size_q - SIZE_W'(1));
  assign last_try    = (tries_q == TryW'(MAX_TRIES - 1));

  // Smallest legal colour; scanning downwards leaves the lowest one.
  // With NO_ADJ at most two colours are excluded and COLOR_NUM >= 3.
  always_comb begin
    fallback = '0;
    for (int i = NumColors - 1; i >= 0; i--) begin
      if (!excluded(COLOR_W'(i), ncol_q, no_adj_q, col_q != '0, left_q, row_q != '0, above)) begin
        fallback = COLOR_W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    error_d    = error_q;
    wr_en_d    = 1'b0;
    wr_row_d   = wr_row_q;
    wr_col_d   = wr_col_q;
    wr_color_d = wr_color_q;
    row_d      = row_q;
    col_d      = col_q;
    size_d     = size_q;
    ncol_d     = ncol_q;
    no_adj_d   = no_adj_q;
    tries_d    = tries_q;
    left_d     = left_q;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;
    rowbuf_we  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (START && !ABORT) begin
          state_d   = StLoad;
          busy_d    = 1'b1;
          size_d    = SIZE;
          ncol_d    = COLOR_NUM;
          no_adj_d  = NO_ADJ;
          lfsr_load = 1'b1;
        end
      end
      StLoad: begin
        if (cfg_bad) begin
          state_d = StErr;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end else begin
          row_d   = '0;
          col_d   = '0;
          tries_d = '0;
          state_d = StDraw;
        end
      end
      StDraw: begin
        lfsr_step = 1'b1;
        if (!cand_reject || last_try) begin
          wr_en_d    = 1'b1;
          wr_row_d   = row_q;
          wr_col_d   = col_q;
          wr_color_d = cand_reject ? fallback : cand;
          state_d    = StWrite;
        end else begin
          tries_d = tries_q + TryW'(1);
        end
      end
      StWrite: begin
        rowbuf_we = 1'b1;
        left_d    = wr_color_q;
        tries_d   = '0;
        if (last_col) begin
          col_d = '0;
          row_d = row_q + SIZE_W'(1);
        end else begin
          col_d = col_q + SIZE_W'(1);
        end
        if (last_col && last_row) begin
          state_d = StDone;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          state_d = StDraw;
        end
      end
      StDone: begin
        if (!START) begin
          ready_d = 1'b0;
          state_d = StIdle;
        end
      end
      StErr: begin
        if (!START) begin
          error_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything outside idle; the partial board stays in RAM.
    if (ABORT && state_q != StIdle) begin
      state_d   = StIdle;
      busy_d    = 1'b0;
      ready_d   = 1'b0;
      error_d   = 1'b0;
      wr_en_d   = 1'b0;
      rowbuf_we = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      wr_color_q <= '0;
      row_q      <= '0;
      col_q      <= '0;
      size_q     <= '0;
      ncol_q     <= '0;
      no_adj_q   <= 1'b0;
      tries_q    <= '0;
      left_q     <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      wr_en_q    <= wr_en_d;
      wr_row_q   <= wr_row_d;
      wr_col_q   <= wr_col_d;
      wr_color_q <= wr_color_d;
      row_q      <= row_d;
      col_q      <= col_d;
      size_q     <= size_d;
      ncol_q     <= ncol_d;
      no_adj_q   <= no_adj_d;
      tries_q    <= tries_d;
      left_q     <= left_d;
    end
  end

  // Colours of the previous row, indexed by column.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < MAX_SIZE; i++) begin
        rowbuf_q[i] <= '0;
      end
    end else if (rowbuf_we) begin
      rowbuf_q[col_q] <= wr_color_q;
    end
  end

  assign WR_EN    = wr_en_q;
  assign WR_ROW   = wr_row_q;
  assign WR_COL   = wr_col_q;
  assign WR_COLOR = wr_color_q;
  assign BUSY     = busy_q;
  assign READY    = ready_q;
  assign ERROR    = error_q;

endmodule

// File: tb/tb_board_gen_param.sv
// Bench for board_gen_param: two instances share stimulus, one with the default
// retry limit and one with a retry limit of 1 (forces fallback colours). An
// abstract board model predicts the write sequence of each; a negedge process
// checks every write against it.
module tb_board_gen_param;

  typedef struct {
    int r;
    int c;
    int col;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        no_adj = 1'b0;
  logic [15:0] seed = '0;
  logic [4:0]  size = '0;
  logic [3:0]  color_num = '0;

  logic       a_wr_en, a_busy, a_ready, a_error;
  logic [4:0] a_wr_row, a_wr_col;
  logic [2:0] a_wr_color;
  logic       b_wr_en, b_busy, b_ready, b_error;
  logic [4:0] b_wr_row, b_wr_col;
  logic [2:0] b_wr_color;

  int  checks = 0;
  int  failures = 0;
  int  na = 0;
  int  nb = 0;
  int  nfb = 0;
  wr_t qa[$];
  wr_t qb[$];
  wr_t tmp[$];

  int e_sz[4] = '{0, 27, 5, 5};
  int e_nc[4] = '{4, 4, 1, 2};
  bit e_na[4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  board_gen_param dut_a (
    .CLOCK     (clk),
    .RESET_N   (rst_n),
    .START     (start),
    .ABORT     (abort),
    .SEED      (seed),
    .SIZE      (size),
    .COLOR_NUM (color_num),
    .NO_ADJ    (no_adj),
    .WR_EN     (a_wr_en),
    .WR_ROW    (a_wr_row),
    .WR_COL    (a_wr_col),
    .WR_COLOR  (a_wr_color),
    .BUSY      (a_busy),
    .READY     (a_ready),
    .ERROR     (a_error)
  );

  board_gen_param #(
    .MAX_TRIES (1)
  ) dut_b (
    .CLOCK     (clk),
    .RESET_N   (rst_n),
    .START     (start),
    .ABORT     (abort),
    .SEED      (seed),
    .SIZE      (size),
    .COLOR_NUM (color_num),
    .NO_ADJ    (no_adj),
    .WR_EN     (b_wr_en),
    .WR_ROW    (b_wr_row),
    .WR_COL    (b_wr_col),
    .WR_COLOR  (b_wr_color),
    .BUSY      (b_busy),
    .READY     (b_ready),
    .ERROR     (b_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned lfsr_next(input int unsigned s);
    return ((s >> 1) ^ (((s & 1) != 0) ? 32'hB400 : 32'h0)) & 32'hFFFF;
  endfunction

  function automatic bit legal(input int c, input int nc, input bit adj, input int r,
                               input int cc, input int left, input int ab);
    if (c >= nc) return 1'b0;
    if (adj && ((cc > 0 && c == left) || (r > 0 && c == ab))) return 1'b0;
    return 1'b1;
  endfunction

  // Whole-board model: the sequence of writes a fresh board must produce.
  task automatic build(input int unsigned seed_in, input int sz, input int nc, input bit adj,
                       input int mt);
    int unsigned s;
    int  above[26];
    int  left;
    int  c;
    int  tries;
    bit  done;
    bit  found;
    wr_t w;
    s = (seed_in == 0) ? 32'hDAD7 : seed_in;
    tmp.delete();
    nfb = 0;
    left = 0;
    for (int i = 0; i < 26; i++) above[i] = 0;
    for (int r = 0; r < sz; r++) begin
      for (int cc = 0; cc < sz; cc++) begin
        tries = 0;
        done = 1'b0;
        c = 0;
        while (!done) begin
          c = int'(s & 7);
          s = lfsr_next(s);
          if (legal(c, nc, adj, r, cc, left, above[cc])) begin
            done = 1'b1;
          end else begin
            tries++;
            if (tries == mt) begin
              found = 1'b0;
              for (int k = 0; k < nc; k++) begin
                if (!found && legal(k, nc, adj, r, cc, left, above[cc])) begin
                  c = k;
                  found = 1'b1;
                end
              end
              nfb++;
              done = 1'b1;
            end
          end
        end
        w.r = r;
        w.c = cc;
        w.col = c;
        tmp.push_back(w);
        above[cc] = c;
        left = c;
      end
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (a_wr_en) begin
      na++;
      chk("a_busy_during_write", int'(a_busy), 1);
      if (qa.size() == 0) begin
        chk("a_unexpected_write", 1, 0);
      end else begin
        e = qa.pop_front();
        chk("a_wr_row", int'(a_wr_row), e.r);
        chk("a_wr_col", int'(a_wr_col), e.c);
        chk("a_wr_color", int'(a_wr_color), e.col);
      end
    end
    if (b_wr_en) begin
      nb++;
      chk("b_busy_during_write", int'(b_busy), 1);
      if (qb.size() == 0) begin
        chk("b_unexpected_write", 1, 0);
      end else begin
        e = qb.pop_front();
        chk("b_wr_row", int'(b_wr_row), e.r);
        chk("b_wr_col", int'(b_wr_col), e.c);
        chk("b_wr_color", int'(b_wr_color), e.col);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_a_outputs"}, int'({a_wr_en, a_wr_row, a_wr_col, a_wr_color, a_busy, a_ready,
                                   a_error}), 0);
    chk({tag, "_b_outputs"}, int'({b_wr_en, b_wr_row, b_wr_col, b_wr_color, b_busy, b_ready,
                                   b_error}), 0);
  endtask

  task automatic load_expect(input int unsigned sd, input int sz, input int nc, input bit adj);
    build(sd, sz, nc, adj, 8);
    qa = tmp;
    build(sd, sz, nc, adj, 1);
    qb = tmp;
    seed = sd[15:0];
    size = sz[4:0];
    color_num = nc[3:0];
    no_adj = adj;
    na = 0;
    nb = 0;
  endtask

  task automatic run_board(input int unsigned sd, input int sz, input int nc, input bit adj);
    int i;
    load_expect(sd, sz, nc, adj);
    start = 1'b1;
    i = 0;
    while (!(a_ready && b_ready) && i < 20000) begin
      tick();
      i++;
    end
    chk("ready_reached", int'(a_ready && b_ready), 1);
    chk("a_write_count", na, sz * sz);
    chk("b_write_count", nb, sz * sz);
    repeat (3) tick();
    chk("a_ready_held", int'(a_ready), 1);
    chk("b_ready_held", int'(b_ready), 1);
    chk("a_busy_in_done", int'(a_busy), 0);
    start = 1'b0;
    tick();
    chk("a_ready_cleared", int'(a_ready), 0);
    chk("b_ready_cleared", int'(b_ready), 0);
    tick();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int n;
    int unsigned sd;

    // Model pins, hand-derived from the LFSR sequence of seed 0x1234.
    build(32'h1234, 5, 4, 1'b0, 8);
    chk("model_pin_a_cell0", tmp[0].col, 2);
    chk("model_pin_a_cell1", tmp[1].col, 3);
    build(32'h1234, 5, 4, 1'b0, 1);
    chk("model_pin_b_cell0", tmp[0].col, 0);
    chk("model_pin_b_cell1", tmp[1].col, 2);

    repeat (2) tick();
    check_all_zero("in_reset");
    rst_n = 1'b1;
    tick();
    check_all_zero("after_reset");

    run_board(32'h1234, 5, 4, 1'b0);
    run_board(32'h0, 26, 6, 1'b1);
    for (int k = 0; k < 3; k++) begin
      sd = $urandom & 32'hFFFF;
      if ($urandom_range(0, 1) == 1) run_board(sd, $urandom_range(3, 8), $urandom_range(3, 8), 1'b1);
      else run_board(sd, $urandom_range(3, 8), $urandom_range(2, 8), 1'b0);
    end
    run_board($urandom & 32'hFFFF, 6, 3, 1'b0);
    chk("fallback_exercised", int'(nfb > 0), 1);
    run_board($urandom & 32'hFFFF, 5, 3, 1'b1);

    // Rejected configurations.
    for (int k = 0; k < 4; k++) begin
      qa.delete();
      qb.delete();
      seed = 16'h1111;
      size = e_sz[k][4:0];
      color_num = e_nc[k][3:0];
      no_adj = e_na[k];
      start = 1'b1;
      tick();
      chk("err_not_early", int'(a_error), 0);
      chk("err_busy_in_load", int'(a_busy), 1);
      tick();
      chk("err_a_raised", int'(a_error), 1);
      chk("err_b_raised", int'(b_error), 1);
      chk("err_busy_off", int'(a_busy), 0);
      repeat (2) tick();
      chk("err_held", int'(a_error), 1);
      start = 1'b0;
      tick();
      chk("err_a_cleared", int'(a_error), 0);
      chk("err_b_cleared", int'(b_error), 0);
    end

    // START together with ABORT in idle is ignored.
    start = 1'b1;
    abort = 1'b1;
    repeat (2) tick();
    chk("start_abort_idle_busy", int'(a_busy), 0);
    start = 1'b0;
    abort = 1'b0;
    tick();

    // Abort on the tenth write of an 8x8 board.
    load_expect($urandom & 32'hFFFF, 8, 4, 1'b0);
    start = 1'b1;
    n = 0;
    i = 0;
    while (n < 10 && i < 5000) begin
      tick();
      if (a_wr_en) n++;
      i++;
    end
    chk("abort_reached_write10", n, 10);
    abort = 1'b1;
    start = 1'b0;
    tick();
    chk("abort_a_busy", int'(a_busy), 0);
    chk("abort_b_busy", int'(b_busy), 0);
    chk("abort_a_wr_en", int'(a_wr_en), 0);
    chk("abort_a_ready", int'(a_ready), 0);
    abort = 1'b0;
    qa.delete();
    qb.delete();
    repeat (5) tick();
    chk("abort_stays_idle", int'(a_busy || a_ready), 0);
    run_board($urandom & 32'hFFFF, 8, 4, 1'b0);

    // Reset in the middle of a 4x4 board.
    sd = $urandom & 32'hFFFF;
    load_expect(sd, 4, 5, 1'b0);
    start = 1'b1;
    n = 0;
    i = 0;
    while (n < 3 && i < 2000) begin
      tick();
      if (a_wr_en) n++;
      i++;
    end
    tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    qa.delete();
    qb.delete();
    start = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_reset_idle", int'(a_busy || b_busy), 0);
    run_board(sd, 4, 5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
